// File: rtl/sync_filter_pkg.sv
// sync_filter_pkg: shared types, defaults and helpers for the input
// synchroniser / glitch-filter bank that sits between the TWI pads and the
// monitor core.
//   filt_state_t - per-channel filter state (STABLE: cnt == 0, QUALIFY: cnt > 0)
//   cnt_width()  - width of the qualification counter for a given FILTER_CYCLES
//   TWI_CH_*     - channel indices shared with the monitor top
package sync_filter_pkg;

  typedef enum logic [0:0] {
    STABLE,
    QUALIFY
  } filt_state_t;

  localparam int unsigned DEF_CHANNELS      = 2;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_FILTER_CYCLES = 3;

  localparam int unsigned TWI_CH_SCL = 0;
  localparam int unsigned TWI_CH_SDA = 1;

  // Counter must hold 0..FILTER_CYCLES-1; sized as clog2(FILTER_CYCLES+1), min 1 bit.
  function automatic int unsigned cnt_width(input int unsigned filter_cycles);
    if (filter_cycles < 1) begin
      return 1;
    end
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// sync_filter_channel: one input channel of the filter bank.
//   N-stage synchroniser -> counter-based glitch filter -> registered edge strobes.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   bypass    1 = skip the glitch filter (level follows synchroniser output)
//   async_in  raw asynchronous input
//   level_out filtered, synchronised level (resets to INIT_BIT)
//   rise      one-cycle pulse on a 0->1 change of level_out
//   fall      one-cycle pulse on a 1->0 change of level_out
module sync_filter_channel
  import sync_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic        INIT_BIT      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic bypass,
  input  logic async_in,
  output logic level_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CntW    = cnt_width(FILTER_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("sync_filter_channel: SYNC_STAGES must be >= 2");
  end
  if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
    $error("sync_filter_channel: FILTER_CYCLES must be >= 1");
  end

  // Plain shift chain, no logic between stages.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{INIT_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

  filt_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, fall_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (bypass) begin
      // Any pending qualification is discarded.
      level_d = sync_bit;
      cnt_d   = '0;
      state_d = STABLE;
    end else if (sync_bit == level_q) begin
      // Input returned before qualifying: glitch rejected.
      cnt_d   = '0;
      state_d = STABLE;
    end else if (cnt_q == CntLast) begin
      level_d = sync_bit;
      cnt_d   = '0;
      state_d = STABLE;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = QUALIFY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= INIT_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= ~level_q & level_d;
      fall_q  <= level_q & ~level_d;
    end
  end

  assign level_out = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;

  // State is a pure function of the counter; the counter never passes FILTER_CYCLES-1.
  state_matches_cnt: assert property (@(posedge clk) disable iff (!reset)
    (state_q == QUALIFY) == (cnt_q != '0));
  cnt_in_range: assert property (@(posedge clk) disable iff (!reset) cnt_q <= CntLast);
  edges_exclusive: assert property (@(posedge clk) disable iff (!reset) !(rise_q && fall_q));

endmodule

// File: rtl/sync_filter_bank.sv
// sync_filter_bank: multi-channel input conditioner for the TWI pads (SCL, SDA)
// and any user inputs. Each channel is an independent sync_filter_channel.
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low reset
//   bypass    1 = skip the glitch filter on every channel
//   async_in  raw asynchronous inputs   [CHANNELS]
//   level_out filtered, synchronised levels [CHANNELS], reset to INIT
//   rise      one-cycle 0->1 strobes [CHANNELS]
//   fall      one-cycle 1->0 strobes [CHANNELS]
module sync_filter_bank
  import sync_filter_pkg::*;
#(
  parameter int unsigned         CHANNELS      = DEF_CHANNELS,
  parameter int unsigned         SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned         FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter logic [CHANNELS-1:0] INIT          = {CHANNELS{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bypass,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("sync_filter_bank: CHANNELS must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    sync_filter_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .INIT_BIT     (INIT[i])
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .bypass   (bypass),
      .async_in (async_in[i]),
      .level_out(level_out[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

endmodule
